// File: rtl/imm_inst_encoder.sv
// Immediate instruction encoder: packs I-load / S-store / B-branch words and tags them with IMEM byte addresses.
// Optional build macro: IMM_RANGE_CHK_EN (drop descriptors whose immediate does not fit its field).

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module imm_inst_encoder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_fmt,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [2:0]             in_funct3,
    input  logic [`DATA_WIDTH-1:0] in_imm,
    input  logic                   addr_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`DATA_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   err
);

    localparam int DW = `DATA_WIDTH;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(32'd4);

    logic                  out_valid_r;
    logic [DW-1:0]         out_inst_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;
    logic [ADDR_WIDTH-1:0] addr_q_r;
    logic                  err_r;

    logic [31:0]           enc_s;
    logic                  fmt_bad_s;
    logic                  range_bad_s;
    logic                  in_hs_s;
    logic                  out_hs_s;
    logic                  drop_s;
    logic                  emit_s;
    logic [ADDR_WIDTH-1:0] addr_next_s;

`ifdef IMM_RANGE_CHK_EN
    // True when the immediate is a sign extension of its low 12 bits.
    function automatic logic fits_simm12(input logic [DW-1:0] imm);
        return (&imm[DW-1:11]) | ~(|imm[DW-1:11]);
    endfunction

    // True when the immediate is an even sign extension of its low 13 bits.
    function automatic logic fits_boff13(input logic [DW-1:0] imm);
        return ((&imm[DW-1:12]) | ~(|imm[DW-1:12])) & ~imm[0];
    endfunction

    // Range violation per format; reserved format is caught by fmt_bad_s.
    always_comb begin
        range_bad_s = 1'b0;
        case (in_fmt)
            2'b00:   range_bad_s = ~fits_simm12(in_imm);
            2'b01:   range_bad_s = ~fits_simm12(in_imm);
            2'b10:   range_bad_s = ~fits_boff13(in_imm);
            default: range_bad_s = 1'b0;
        endcase
    end
`else
    // Without range checking the immediate is simply truncated to its field bits.
    logic unused_imm_s;
    assign unused_imm_s = ^in_imm[DW-1:13];
    assign range_bad_s  = 1'b0;
`endif

    // Field packing for the three supported formats; 2'b11 is the reserved drop format.
    always_comb begin
        enc_s     = 32'h0000_0000;
        fmt_bad_s = 1'b0;
        case (in_fmt)
            2'b00:   enc_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            2'b01:   enc_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            2'b10:   enc_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], OP_BRANCH};
            default: fmt_bad_s = 1'b1;
        endcase
    end

    // Handshake qualification: a dropped descriptor still completes its input handshake.
    always_comb begin
        in_ready = ~out_valid_r | out_ready;
        in_hs_s  = in_valid & in_ready;
        out_hs_s = out_valid_r & out_ready;
        drop_s   = in_hs_s & (fmt_bad_s | range_bad_s);
        emit_s   = in_hs_s & ~(fmt_bad_s | range_bad_s);
    end

    // Next address: clear beats the post-handshake increment; the add wraps naturally.
    always_comb begin
        if (addr_clr) begin
            addr_next_s = BASE_ADDR;
        end else if (out_hs_s) begin
            addr_next_s = addr_q_r + ADDR_STEP;
        end else begin
            addr_next_s = addr_q_r;
        end
    end

    // Output stage, address counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_inst_r  <= {DW{1'b0}};
            out_addr_r  <= BASE_ADDR;
            addr_q_r    <= BASE_ADDR;
            err_r       <= 1'b0;
        end else begin
            addr_q_r <= addr_next_s;
            // A new word takes the address the counter holds after this cycle's update.
            if (emit_s) begin
                out_valid_r <= 1'b1;
                out_inst_r  <= DW'(enc_s);
                out_addr_r  <= addr_next_s;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end
            if (drop_s) begin
                err_r <= 1'b1;
            end else if (addr_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_inst  = out_inst_r;
    assign out_addr  = out_addr_r;
    assign err       = err_r;

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench for imm_inst_encoder: directed examples, a small-address-width
// instance for wrap/clear, then randomized traffic against a transaction-level reference.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_imm_inst_encoder;

    localparam int DW = `DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, addr_clr, out_valid, out_ready, err;
    logic [1:0]    in_fmt;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [2:0]    in_funct3;
    logic [DW-1:0] in_imm, out_inst;
    logic [31:0]   out_addr;

    logic          in_valid4, in_ready4, addr_clr4, out_valid4, out_ready4, err4;
    logic [DW-1:0] out_inst4;
    logic [3:0]    out_addr4;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference state: the word the consumer should see, plus counter and error flag.
    bit          m_valid, m_err;
    logic [31:0] m_inst, m_addr, m_aq;

    always #5 clk = ~clk;

    imm_inst_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_imm(in_imm), .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .err(err)
    );

    imm_inst_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(4'hC)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_fmt(in_fmt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_imm(in_imm), .addr_clr(addr_clr4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_inst(out_inst4), .out_addr(out_addr4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction word built by shifting fields into place arithmetically.
    function automatic logic [31:0] ref_enc(input logic [1:0] f, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input int imm);
        logic [31:0] u;
        logic [31:0] common;
        u = imm;
        common = (32'(rs1) << 15) | (32'(f3) << 12);
        if (f == 2'd0)
            return ((u & 32'hFFF) << 20) | common | (32'(rd) << 7) | 32'h03;
        else if (f == 2'd1)
            return (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | common
                 | ((u & 32'h1F) << 7) | 32'h23;
        else
            return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                 | (32'(rs2) << 20) | common | (((u >> 1) & 32'hF) << 8)
                 | (((u >> 11) & 32'h1) << 7) | 32'h63;
    endfunction

    function automatic bit ref_bad(input logic [1:0] f, input int imm);
        if (f == 2'd3) return 1'b1;
`ifdef IMM_RANGE_CHK_EN
        if (f == 2'd2) return !(imm >= -4096 && imm <= 4094 && (imm % 2) == 0);
        return !(imm >= -2048 && imm <= 2047);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int rand_imm();
        int bnd[10] = '{-4097, -4096, -2049, -2048, -1, 2047, 2048, 4094, 4095, 4096};
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 4095)) - 2048;
            1:       return int'($urandom_range(0, 8191)) - 4096;
            2:       return int'($urandom);
            default: return bnd[$urandom_range(0, 9)];
        endcase
    endfunction

    // One clock: check in_ready, predict, step the clock, check outputs. Entered after negedge.
    task automatic tick();
        bit          hs, ohs, bad;
        bit          n_valid, n_err;
        logic [31:0] n_inst, n_addr, n_aq;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        hs  = in_valid && (!m_valid || out_ready);
        ohs = m_valid && out_ready;
        bad = ref_bad(in_fmt, int'($signed(in_imm)));
        n_valid = m_valid; n_inst = m_inst; n_addr = m_addr; n_err = m_err;
        if (rst) begin
            n_valid = 0; n_inst = 0; n_addr = 0; n_aq = 0; n_err = 0;
        end else begin
            n_aq = addr_clr ? 32'h0 : (ohs ? m_aq + 32'd4 : m_aq);
            if (hs && !bad) begin
                n_valid = 1;
                n_inst  = ref_enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, int'($signed(in_imm)));
                n_addr  = n_aq;
            end else if (ohs) begin
                n_valid = 0;
            end
            if (hs && bad) n_err = 1;
            else if (addr_clr) n_err = 0;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_inst = n_inst; m_addr = n_addr; m_aq = n_aq; m_err = n_err;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("err", 32'(err), 32'(m_err));
        if (m_valid) begin
            chk("out_inst", out_inst, m_inst);
            chk("out_addr", out_addr, m_addr);
        end
        @(negedge clk);
    endtask

    task automatic set_desc(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [2:0] f3, input int imm);
        in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; addr_clr = 0; out_ready = 1;
        in_valid4 = 0; addr_clr4 = 0; out_ready4 = 1;
        set_desc(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_valid = 0; m_inst = 0; m_addr = 0; m_aq = 0; m_err = 0;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Narrow counter: 0xC, wrap to 0x0, then clear with a same-cycle handshake.
        set_desc(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 4);
        in_valid4 = 1;
        tick();
        chk("a4_first_valid", 32'(out_valid4), 32'h1);
        chk("a4_first_addr", 32'(out_addr4), 32'hC);
        tick();
        chk("a4_wrap_addr", 32'(out_addr4), 32'h0);
        addr_clr4 = 1;
        tick();
        chk("a4_clr_addr", 32'(out_addr4), 32'hC);
        addr_clr4 = 0; in_valid4 = 0;

        // Worked examples from the encoding rules.
        in_valid = 1;
        set_desc(2'd0, 5'd5, 5'd2, 5'd31, 3'b010, 8);
        tick();
        chk("ex_I_inst", out_inst, 32'h00812283);
        chk("ex_I_addr", out_addr, 32'h0);
        set_desc(2'd1, 5'd17, 5'd2, 5'd6, 3'b010, -4);
        tick();
        chk("ex_S_inst", out_inst, 32'hFE612E23);
        chk("ex_S_addr", out_addr, 32'h4);
        set_desc(2'd2, 5'd9, 5'd1, 5'd2, 3'b000, -8);
        tick();
        chk("ex_B_inst", out_inst, 32'hFE208CE3);
        chk("ex_B_addr", out_addr, 32'h8);

        // Back-pressure for three cycles, then release for back-to-back words.
        out_ready = 0;
        set_desc(2'd0, 5'd3, 5'd4, 5'd0, 3'b001, 100);
        repeat (3) begin
            tick();
            chk("stall_inst", out_inst, 32'hFE208CE3);
            chk("stall_addr", out_addr, 32'h8);
        end
        out_ready = 1;
        repeat (3) tick();

        // Out-of-range I immediate.
        set_desc(2'd0, 5'd7, 5'd8, 5'd0, 3'b000, 4096);
        tick();
`ifdef IMM_RANGE_CHK_EN
        chk("imm4096_err", 32'(err), 32'h1);
`else
        chk("imm4096_field", 32'(out_inst[31:20]), 32'h0);
`endif
        set_desc(2'd0, 5'd7, 5'd8, 5'd0, 3'b000, 1);
        tick();

        // Reserved format drop followed by a clear.
        set_desc(2'd3, 5'd1, 5'd1, 5'd1, 3'b000, 0);
        tick();
        chk("fmt11_err", 32'(err), 32'h1);
        in_valid = 0; addr_clr = 1;
        tick();
        chk("clr_err", 32'(err), 32'h0);
        addr_clr = 0;

        // Randomized traffic, including same-cycle clear/drop and mid-transfer reset.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_clr  = ($urandom_range(0, 15) == 0);
            set_desc(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
                     3'($urandom), rand_imm());
            tick();
            if (rst) chk("rand_rst_inst", out_inst, 32'h0);
        end
        rst = 0; in_valid = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
